ps2_key_sequencer: RTL and testbench

PS2_KEY_SEQUENCER -- requirements
Module: ps2_key_sequencer

---
 rtl/ps2_pkg.sv | 41 ++++
 rtl/ps2_event_fifo.sv | 65 ++++++
 rtl/ps2_key_sequencer.sv | 152 +++++++++++++++
 tb/tb_ps2_key_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared scan-code constants, decoder state type and event record for the
// PS/2 key sequencer.
package ps2_pkg;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_NUL    = 8'h00;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ERR    = 8'hFF;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_UP     = 8'h75;

  // Pause (E1 ...) is eight bytes long; the leading E1 is consumed on entry.
  localparam logic [3:0] SKIP_LEN  = 4'd7;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GOT_E0   = 3'd1,
    GOT_F0   = 3'd2,
    GOT_E0F0 = 3'd3,
    SKIP     = 3'd4
  } ps2_state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ps2_evt_t;

  function automatic logic is_filtered(input logic [7:0] b);
    case (b)
      SC_NUL, SC_BAT, SC_ECHO, SC_ACK, SC_RESEND, SC_ERR: return 1'b1;
      default:                                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Small synchronous FIFO holding completed key events; a push into a full
// queue is taken only when a pop frees a slot in the same cycle.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  ps2_evt_t push_data,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output ps2_evt_t head
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

  ps2_evt_t       mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [AW:0]    count_r;
  logic           wr_en_s;
  logic           rd_en_s;

  assign full  = (count_r == CNT_MAX);
  assign empty = (count_r == '0);
  assign head  = mem_r[rd_ptr_r];

  // Qualify pop/push against occupancy.
  always_comb begin
    rd_en_s = pop && !empty;
    wr_en_s = push && (!full || rd_en_s);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_sequencer.sv
// Decodes PS/2 set-2 scan-code bytes into make/break events, queues them and
// tracks the jump keys (Space, Up arrow) as held flags plus a press strobe.
module ps2_key_sequencer
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_byte_valid,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       jump_held,
  output logic       jump_pulse,
  output logic       overflow
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);

  ps2_state_t  state_r;
  logic [3:0]  skip_cnt_r;
  logic [TW-1:0] to_cnt_r;
  logic        space_held_r;
  logic        up_held_r;
  logic        jump_held_r;
  logic        jump_pulse_r;
  logic        overflow_r;

  ps2_evt_t    evt_s;
  ps2_evt_t    head_s;
  logic        evt_done_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic        pop_s;
  logic        space_next_s;
  logic        up_next_s;
  logic        fresh_jump_s;

  assign evt_valid  = !fifo_empty_s;
  assign evt_code   = head_s.code;
  assign evt_ext    = head_s.ext;
  assign evt_break  = head_s.brk;
  assign jump_held  = jump_held_r;
  assign jump_pulse = jump_pulse_r;
  assign overflow   = overflow_r;

  // Event completion and next held-flag values for the current strobe.
  always_comb begin
    evt_s.code   = ps2_byte;
    evt_s.ext    = (state_r == GOT_E0) || (state_r == GOT_E0F0);
    evt_s.brk    = (state_r == GOT_F0) || (state_r == GOT_E0F0);
    evt_done_s   = 1'b0;
    space_next_s = space_held_r;
    up_next_s    = up_held_r;
    fresh_jump_s = 1'b0;
    pop_s        = evt_valid && evt_ready;
    if (ps2_byte_valid && (state_r != SKIP) && !is_filtered(ps2_byte) &&
        (ps2_byte != SC_E0) && (ps2_byte != SC_E1) && (ps2_byte != SC_F0)) begin
      evt_done_s = 1'b1;
    end else begin
      evt_done_s = 1'b0;
    end
    if (evt_done_s && !evt_s.ext && (evt_s.code == SC_SPACE)) begin
      space_next_s = !evt_s.brk;
      fresh_jump_s = !evt_s.brk && !space_held_r;
    end else if (evt_done_s && evt_s.ext && (evt_s.code == SC_UP)) begin
      up_next_s    = !evt_s.brk;
      fresh_jump_s = !evt_s.brk && !up_held_r;
    end else begin
      fresh_jump_s = 1'b0;
    end
  end

  // Decode FSM, prefix/skip timeout, held flags and sticky overflow.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_r      <= IDLE;
      skip_cnt_r   <= 4'd0;
      to_cnt_r     <= '0;
      space_held_r <= 1'b0;
      up_held_r    <= 1'b0;
      jump_held_r  <= 1'b0;
      jump_pulse_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      space_held_r <= space_next_s;
      up_held_r    <= up_next_s;
      jump_held_r  <= space_next_s || up_next_s;
      jump_pulse_r <= fresh_jump_s;
      if (evt_done_s && fifo_full_s && !pop_s) begin
        overflow_r <= 1'b1;
      end
      if (ps2_byte_valid) begin
        to_cnt_r <= '0;
        if (state_r == SKIP) begin
          skip_cnt_r <= skip_cnt_r - 4'd1;
          if (skip_cnt_r == 4'd1) begin
            state_r <= IDLE;
          end
        end else if (!is_filtered(ps2_byte)) begin
          case (ps2_byte)
            SC_E0: state_r <= GOT_E0;
            SC_F0: begin
              if (state_r == IDLE) begin
                state_r <= GOT_F0;
              end else if (state_r == GOT_E0) begin
                state_r <= GOT_E0F0;
              end
            end
            SC_E1: begin
              state_r    <= SKIP;
              skip_cnt_r <= SKIP_LEN;
            end
            default: state_r <= IDLE;
          endcase
        end
      end else if (state_r != IDLE) begin
        // Abandon a stalled prefix or pause sequence.
        if (to_cnt_r == TO_LAST) begin
          state_r    <= IDLE;
          skip_cnt_r <= 4'd0;
          to_cnt_r   <= '0;
        end else begin
          to_cnt_r <= to_cnt_r + TO_ONE;
        end
      end else begin
        to_cnt_r <= '0;
      end
    end
  end

  ps2_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLOCK_50),
    .rst_n    (resetn),
    .push     (evt_done_s),
    .push_data(evt_s),
    .pop      (pop_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .head     (head_s)
  );

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed bench for ps2_key_sequencer: a vector table of byte sequences with
// expected head events, plus hand-written timeout, pause, queue and reset cases.
module tb_ps2_key_sequencer;

  localparam int TO = 20;
  localparam int DEPTH = 4;

  logic       CLOCK_50 = 1'b0;
  logic       resetn;
  logic [7:0] ps2_byte;
  logic       ps2_byte_valid;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       jump_held;
  logic       jump_pulse;
  logic       overflow;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [23:0] bytes;
    int          n;
    logic [7:0]  code;
    logic        ext;
    logic        brk;
    logic        pulse;
    logic        held;
  } vec_t;

  vec_t tbl[11];

  ps2_key_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .CLOCK_50      (CLOCK_50),
    .resetn        (resetn),
    .ps2_byte      (ps2_byte),
    .ps2_byte_valid(ps2_byte_valid),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_code      (evt_code),
    .evt_ext       (evt_ext),
    .evt_break     (evt_break),
    .jump_held     (jump_held),
    .jump_pulse    (jump_pulse),
    .overflow      (overflow)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Present one byte for exactly one rising edge; returns on the following falling edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge CLOCK_50);
    ps2_byte       = b;
    ps2_byte_valid = 1'b1;
    @(negedge CLOCK_50);
    ps2_byte_valid = 1'b0;
  endtask

  task automatic pop_expect(input string nm, input logic [7:0] code);
    chk({nm, " valid"}, {31'd0, evt_valid}, 32'd1);
    chk({nm, " code"}, {24'd0, evt_code}, {24'd0, code});
    evt_ready = 1'b1;
    @(negedge CLOCK_50);
    evt_ready = 1'b0;
  endtask

  task automatic expect_event(input string nm, input logic [7:0] code, input logic ext,
                              input logic brk);
    chk({nm, " valid"}, {31'd0, evt_valid}, 32'd1);
    chk({nm, " code"}, {24'd0, evt_code}, {24'd0, code});
    chk({nm, " ext"}, {31'd0, evt_ext}, {31'd0, ext});
    chk({nm, " brk"}, {31'd0, evt_break}, {31'd0, brk});
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, " valid"}, {31'd0, evt_valid}, 32'd0);
    chk({nm, " code"}, {24'd0, evt_code}, 32'd0);
    chk({nm, " ext"}, {31'd0, evt_ext}, 32'd0);
    chk({nm, " brk"}, {31'd0, evt_break}, 32'd0);
    chk({nm, " held"}, {31'd0, jump_held}, 32'd0);
    chk({nm, " pulse"}, {31'd0, jump_pulse}, 32'd0);
    chk({nm, " overflow"}, {31'd0, overflow}, 32'd0);
  endtask

  initial begin
    logic [23:0] vb;

    tbl[0]  = '{24'h290000, 1, 8'h29, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[1]  = '{24'h290000, 1, 8'h29, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{24'hF02900, 2, 8'h29, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{24'hE07500, 2, 8'h75, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{24'hE0F075, 3, 8'h75, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{24'h750000, 1, 8'h75, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{24'hE0FA1C, 3, 8'h1C, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{24'hAA1C00, 2, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{24'hF0E01C, 3, 8'h1C, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{24'hF0001C, 3, 8'h1C, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{24'hE0F0F0, 3, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

    resetn         = 1'b0;
    ps2_byte       = 8'h00;
    ps2_byte_valid = 1'b0;
    evt_ready      = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check_reset_outputs("reset");
    resetn = 1'b1;
    @(negedge CLOCK_50);

    for (int i = 0; i < 10; i++) begin
      vb = tbl[i].bytes;
      for (int j = 0; j < tbl[i].n; j++) begin
        send_byte(vb[23:16]);
        vb = vb << 8;
      end
      expect_event($sformatf("vec%0d", i), tbl[i].code, tbl[i].ext, tbl[i].brk);
      chk($sformatf("vec%0d pulse", i), {31'd0, jump_pulse}, {31'd0, tbl[i].pulse});
      chk($sformatf("vec%0d held", i), {31'd0, jump_held}, {31'd0, tbl[i].held});
      evt_ready = 1'b1;
      @(negedge CLOCK_50);
      evt_ready = 1'b0;
      chk($sformatf("vec%0d drained", i), {31'd0, evt_valid}, 32'd0);
      chk($sformatf("vec%0d pulse gone", i), {31'd0, jump_pulse}, 32'd0);
    end

    // Prefix-only sequence (E0 F0 F0) followed by 1C must keep ext and brk.
    vb = tbl[10].bytes;
    for (int j = 0; j < tbl[10].n; j++) begin
      send_byte(vb[23:16]);
      vb = vb << 8;
    end
    chk("prefix only no event", {31'd0, evt_valid}, 32'd0);
    send_byte(8'h1C);
    expect_event("e0f0f0 1c", 8'h1C, 1'b1, 1'b1);
    pop_expect("e0f0f0 pop", 8'h1C);

    // Timeout boundary: strobe on the timeout edge itself still sees the prefix.
    send_byte(8'hE0);
    repeat (TO - 2) @(negedge CLOCK_50);
    send_byte(8'h1C);
    expect_event("to edge", 8'h1C, 1'b1, 1'b0);
    pop_expect("to edge pop", 8'h1C);
    send_byte(8'hE0);
    repeat (TO - 1) @(negedge CLOCK_50);
    send_byte(8'h1C);
    expect_event("to expired", 8'h1C, 1'b0, 1'b0);
    pop_expect("to expired pop", 8'h1C);
    send_byte(8'hE0);
    repeat (TO + 5) @(negedge CLOCK_50);
    chk("to no event", {31'd0, evt_valid}, 32'd0);
    send_byte(8'h1C);
    expect_event("to long", 8'h1C, 1'b0, 1'b0);
    pop_expect("to long pop", 8'h1C);

    // Pause sequence is swallowed entirely.
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
    send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
    chk("pause no event", {31'd0, evt_valid}, 32'd0);
    send_byte(8'h1C);
    expect_event("after pause", 8'h1C, 1'b0, 1'b0);
    pop_expect("after pause pop", 8'h1C);
    chk("after pause single", {31'd0, evt_valid}, 32'd0);

    // Push into a full queue while it is popped: accepted, no overflow.
    send_byte(8'h16); send_byte(8'h1E); send_byte(8'h26); send_byte(8'h25);
    chk("full no ovf", {31'd0, overflow}, 32'd0);
    @(negedge CLOCK_50);
    ps2_byte       = 8'h2E;
    ps2_byte_valid = 1'b1;
    evt_ready      = 1'b1;
    @(negedge CLOCK_50);
    ps2_byte_valid = 1'b0;
    evt_ready      = 1'b0;
    chk("push+pop full no ovf", {31'd0, overflow}, 32'd0);
    pop_expect("pp0", 8'h1E);
    pop_expect("pp1", 8'h26);
    pop_expect("pp2", 8'h25);
    pop_expect("pp3", 8'h2E);
    chk("pp empty", {31'd0, evt_valid}, 32'd0);

    // Overflow: fifth event dropped, first four drain in order.
    send_byte(8'h15); send_byte(8'h1D); send_byte(8'h24); send_byte(8'h2D);
    chk("ovf not yet", {31'd0, overflow}, 32'd0);
    send_byte(8'h2C);
    chk("ovf set", {31'd0, overflow}, 32'd1);
    pop_expect("drain0", 8'h15);
    pop_expect("drain1", 8'h1D);
    pop_expect("drain2", 8'h24);
    pop_expect("drain3", 8'h2D);
    chk("drain empty", {31'd0, evt_valid}, 32'd0);
    chk("ovf sticky", {31'd0, overflow}, 32'd1);

    // Reset in the middle of a break prefix discards it.
    send_byte(8'h29);
    chk("pre-reset held", {31'd0, jump_held}, 32'd1);
    send_byte(8'hF0);
    @(negedge CLOCK_50);
    resetn = 1'b0;
    #1;
    check_reset_outputs("mid reset");
    @(negedge CLOCK_50);
    resetn = 1'b1;
    send_byte(8'h29);
    expect_event("post reset", 8'h29, 1'b0, 1'b0);
    chk("post reset pulse", {31'd0, jump_pulse}, 32'd1);
    chk("post reset held", {31'd0, jump_held}, 32'd1);
    @(negedge CLOCK_50);
    chk("post reset pulse once", {31'd0, jump_pulse}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
